// File: rtl/mem_port_arb.sv
// mem_port_arb: two-requester (fetch / data) arbiter onto a single memory port.
// One transfer outstanding at a time: IDLE -> GRANT_x -> RESP -> IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin contention
// resolution; otherwise data has priority with a fetch starvation limit.
module mem_port_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch requester
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic [63:0] i_rdata,
  output logic        i_ack,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wstrb,
  output logic [63:0] d_rdata,
  output logic        d_ack,
  // shared memory port
  output logic        m_req,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [63:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t      r_state, w_nxt;
  logic        w_grant, w_grant_d, w_data_pref;
  logic [63:0] r_addr, r_wdata, r_i_rdata, r_d_rdata;
  logic [7:0]  r_wstrb;
  logic        r_we, r_win_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was granted last, 0 = fetch was granted last
  logic r_last;
  assign w_data_pref = ~r_last;

  // last-granted pointer moves on every grant
  always_ff @(posedge clk) begin
    if (rst)          r_last <= 1'b0;
    else if (w_grant) r_last <= w_grant_d;
  end
`else
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_cnt;
  assign w_data_pref = (r_cnt != CW'(STARVE_LIMIT));

  // starvation counter: counts data grants that passed over a waiting fetch
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_grant) begin
      if (!w_grant_d)                              r_cnt <= '0;
      else if (i_req && r_cnt != CW'(STARVE_LIMIT)) r_cnt <= r_cnt + 1'b1;
    end
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // next state and winner selection; requests only looked at in IDLE
  always_comb begin
    w_nxt     = r_state;
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: if (i_req || d_req) begin
        w_grant   = 1'b1;
        w_grant_d = d_req && (!i_req || w_data_pref);
        w_nxt     = w_grant_d ? GRANT_D : GRANT_I;
      end
      GRANT_I, GRANT_D: if (m_ready) w_nxt = RESP;
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // request latch at grant, read data capture at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_we      <= 1'b0;
      r_win_d   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_addr  <= w_grant_d ? d_addr  : i_addr;
        r_wdata <= w_grant_d ? d_wdata : '0;
        r_wstrb <= w_grant_d ? d_wstrb : '0;
        r_we    <= w_grant_d & d_we;
        r_win_d <= w_grant_d;
      end
      if (m_req && m_ready) begin
        if (r_win_d) r_d_rdata <= m_rdata;
        else         r_i_rdata <= m_rdata;
      end
    end
  end

  assign m_req   = (r_state == GRANT_I) || (r_state == GRANT_D);
  assign m_we    = m_req & r_we;
  assign m_wstrb = m_req ? r_wstrb : 8'h00;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign i_ack   = (r_state == RESP) && !r_win_d;
  assign d_ack   = (r_state == RESP) &&  r_win_d;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized traffic with occasional resets.
module tb_mem_port_arb;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 0, d_req = 0, d_we = 0, m_ready = 0;
  logic [63:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [7:0]  d_wstrb = 0;
  logic [63:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic        i_ack, d_ack, m_req, m_we, busy;

  mem_port_arb #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // pending transfer record, ack owed (0 none, 1 fetch, 2 data), per-requester
  // read data, starvation count and last winner
  bit          p_vld;
  bit          p_dat;
  bit          p_we;
  logic [63:0] p_addr, p_wdata;
  logic [7:0]  p_wstrb;
  int          ack_due;
  logic [63:0] mi_rdata, md_rdata;
  int          starve;
  bit          last_d;

  always @(posedge clk) begin
    bit win_d;
    if (rst) begin
      p_vld = 0; ack_due = 0; mi_rdata = 0; md_rdata = 0; starve = 0; last_d = 0;
    end else if (ack_due != 0) begin
      ack_due = 0;
    end else if (p_vld) begin
      if (m_ready) begin
        if (p_dat) md_rdata = m_rdata; else mi_rdata = m_rdata;
        ack_due = p_dat ? 2 : 1;
        p_vld = 0;
      end
    end else if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = d_req && (!i_req || !last_d);
`else
      win_d = d_req && (!i_req || starve != LIM);
`endif
      p_vld = 1; p_dat = win_d;
      p_addr  = win_d ? d_addr : i_addr;
      p_wdata = win_d ? d_wdata : 64'h0;
      p_wstrb = win_d ? d_wstrb : 8'h0;
      p_we    = win_d & d_we;
      if (!win_d) starve = 0;
      else if (i_req && starve < LIM) starve++;
      last_d = win_d;
    end
  end

  // compare DUT against model on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_req",   m_req,   p_vld);
      chk("busy",    busy,    p_vld || ack_due != 0);
      chk("i_ack",   i_ack,   ack_due == 1);
      chk("d_ack",   d_ack,   ack_due == 2);
      chk("i_rdata", i_rdata, mi_rdata);
      chk("d_rdata", d_rdata, md_rdata);
      if (p_vld) begin
        chk("m_addr",  m_addr,  p_addr);
        chk("m_wdata", m_wdata, p_wdata);
        chk("m_we",    m_we,    p_we);
        chk("m_wstrb", m_wstrb, p_wstrb);
      end else begin
        chk("m_we_idle",    m_we,    0);
        chk("m_wstrb_idle", m_wstrb, 0);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    i_req = 0; d_req = 0; d_we = 0; m_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1; quiet(); cyc(); cyc(); rst = 0;
  endtask

  initial begin
    string exp_s;
    int    got_ack, to;
    quiet();
    cyc(); cyc(); rst = 0; cmp_en = 1;

    // reset state
    do_reset();
    chk("rst_m_addr",  m_addr,  0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_m_req",   m_req,   0);
    chk("rst_i_rdata", i_rdata, 0);

    // single fetch, minimum latency
    i_req = 1; i_addr = 64'h8000_0000; m_ready = 1; m_rdata = 64'h13;
    cyc();
    chk("f_m_req",  m_req,  1);
    chk("f_m_addr", m_addr, 64'h8000_0000);
    chk("f_m_we",   m_we,   0);
    i_req = 0;
    cyc();
    chk("f_i_ack",   i_ack,   1);
    chk("f_i_rdata", i_rdata, 64'h13);
    chk("f_d_ack",   d_ack,   0);
    cyc();
    chk("f_idle_busy", busy, 0);

    // contention: both held, grant order
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_s = "DIDIDI";
`else
    exp_s = "DDDDID";
`endif
    i_req = 1; d_req = 1; m_ready = 1; d_we = 0;
    for (int k = 0; k < 6; k++) begin
      got_ack = 0; to = 0;
      while (!got_ack && to < 10) begin
        cyc(); to++;
        if (i_ack || d_ack) begin
          got_ack = 1;
          chk("seq_grant", d_ack ? "D" : "I", exp_s[k]);
        end
      end
      if (!got_ack) chk("seq_timeout", 0, 1);
    end
    quiet(); cyc(); cyc(); cyc();

    // wait states on a data write, request dropped during grant
    d_req = 1; d_we = 1; d_addr = 64'h100; d_wdata = 64'hDEAD; d_wstrb = 8'h0F;
    m_ready = 0; m_rdata = 64'h55;
    cyc();
    d_req = 0; d_we = 0; d_addr = 64'h0; d_wdata = 64'h0; d_wstrb = 8'h0;
    for (int w = 0; w < 3; w++) begin
      chk("ws_m_req",   m_req,   1);
      chk("ws_m_addr",  m_addr,  64'h100);
      chk("ws_m_wdata", m_wdata, 64'hDEAD);
      chk("ws_m_wstrb", m_wstrb, 8'h0F);
      chk("ws_m_we",    m_we,    1);
      chk("ws_no_ack",  d_ack,   0);
      if (w == 2) m_ready = 1;
      cyc();
    end
    chk("ws_d_ack",   d_ack,   1);
    chk("ws_d_rdata", d_rdata, 64'h55);
    cyc();

    // reset mid-transfer
    d_req = 1; m_ready = 0; d_addr = 64'h200;
    cyc();
    chk("rm_m_req", m_req, 1);
    rst = 1; d_req = 0;
    cyc();
    rst = 0; m_ready = 1;
    chk("rm_m_req_drop", m_req, 0);
    chk("rm_busy",       busy,  0);
    chk("rm_d_ack",      d_ack, 0);
    for (int w = 0; w < 3; w++) begin
      cyc();
      chk("rm_no_ack", d_ack | i_ack, 0);
    end

    // request held through ack
    d_req = 1; d_addr = 64'h300; m_ready = 1;
    cyc(); chk("hold_grant", m_req, 1);
    cyc(); chk("hold_ack",   d_ack, 1);
    cyc();
    chk("hold_no_ack2", d_ack, 0);
    chk("hold_idle",    busy,  0);
    chk("hold_no_mreq", m_req, 0);
    cyc(); chk("hold_regrant", m_req, 1);
    quiet(); cyc(); cyc(); cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 249) == 0);
      i_req   = ($urandom_range(0, 1) == 1);
      d_req   = ($urandom_range(0, 1) == 1);
      d_we    = $urandom_range(0, 1);
      i_addr  = {$urandom, $urandom};
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
      d_wstrb = 8'($urandom);
      m_ready = ($urandom_range(0, 9) < 7);
      m_rdata = {$urandom, $urandom};
      cyc();
    end
    rst = 0; quiet(); cyc(); cyc(); cyc(); cyc();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
